// File: rtl/decoder_pkg.sv
// Shared definitions for the pipelined instruction decoder.
//   - Width constants for the instruction, immediates and register fields
//   - Bit positions of the fixed instruction fields
//   - Instruction class enum, taken from {bc,ct} = instr[31:29]
//   - Decoded-bundle struct carried through the main/skid entries
//   - Sign-extension helpers for the short and jump immediates
package decoder_pkg;

  localparam int INST_W = 32;
  localparam int XLEN   = 32;
  localparam int OPC_W  = 5;
  localparam int REG_W  = 5;
  localparam int IMM_W  = 14;
  localparam int JIMM_W = 19;
  localparam int SYS_W  = 24;

  localparam int BC_HI  = 31;
  localparam int BC_LO  = 30;
  localparam int CT_BIT = 29;
  localparam int OPC_HI = 28;
  localparam int OPC_LO = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 19;
  localparam int RS1_HI = 18;
  localparam int RS1_LO = 14;
  localparam int RS2_HI = 13;
  localparam int RS2_LO = 9;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LD  = 3'd2,
    CLS_ST  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_J   = 3'd5,
    CLS_SYS = 3'd6,
    CLS_ILL = 3'd7
  } cls_e;

  typedef struct packed {
    logic [1:0]       bc;
    logic             ct;
    cls_e             cls;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [XLEN-1:0]  imm;
    logic [SYS_W-1:0] sys;
    logic             illegal;
  } dec_bundle_t;

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(XLEN-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] sext_jimm(input logic [JIMM_W-1:0] v);
    return {{(XLEN-JIMM_W){v[JIMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/decoder_field_ext.sv
// Combinational field extractor: splits a raw instruction into a decoded
// bundle according to its class. Fields a class does not use are zero.
//   instr_i   in  INST_W  raw instruction
//   bundle_o  out         decoded bundle (dec_bundle_t)
module decoder_field_ext
  import decoder_pkg::*;
(
  input  logic [INST_W-1:0] instr_i,
  output dec_bundle_t       bundle_o
);

  always_comb begin
    bundle_o        = '0;
    bundle_o.bc     = instr_i[BC_HI:BC_LO];
    bundle_o.ct     = instr_i[CT_BIT];
    bundle_o.cls    = cls_e'(instr_i[BC_HI:CT_BIT]);
    bundle_o.opcode = instr_i[OPC_HI:OPC_LO];
    unique case (cls_e'(instr_i[BC_HI:CT_BIT]))
      CLS_R: begin
        bundle_o.rd  = instr_i[RD_HI:RD_LO];
        bundle_o.rs1 = instr_i[RS1_HI:RS1_LO];
        bundle_o.rs2 = instr_i[RS2_HI:RS2_LO];
      end
      CLS_I, CLS_LD: begin
        bundle_o.rd  = instr_i[RD_HI:RD_LO];
        bundle_o.rs1 = instr_i[RS1_HI:RS1_LO];
        bundle_o.imm = sext_imm(instr_i[IMM_W-1:0]);
      end
      // Stores and branches have no destination; the rd slot names rs2.
      CLS_ST, CLS_BR: begin
        bundle_o.rs2 = instr_i[RD_HI:RD_LO];
        bundle_o.rs1 = instr_i[RS1_HI:RS1_LO];
        bundle_o.imm = sext_imm(instr_i[IMM_W-1:0]);
      end
      CLS_J: begin
        bundle_o.rd  = instr_i[RD_HI:RD_LO];
        bundle_o.imm = sext_jimm(instr_i[JIMM_W-1:0]);
      end
      CLS_SYS: begin
        bundle_o.sys = instr_i[SYS_W-1:0];
      end
      default: begin
        bundle_o.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered, flow-controlled instruction decoder between fetch and
// register-read. A main entry drives the outputs; a skid entry absorbs one
// bundle so that in_ready comes straight from a flop (in_ready = !skid valid).
// Optional feature macro: DECODER_PIPE_PERF_CNT_EN adds perf_dec_cnt and
// perf_ill_cnt (output-fire and illegal-output-fire counters, not flushed).
//   clk, rst_n           clock, synchronous active-low reset
//   flush                drop main and skid entries (highest priority)
//   in_valid/in_ready    input handshake, instruction = raw instruction
//   out_valid/out_ready  output handshake
//   bc_o..illegal_o      decoded fields of the main entry
module decoder_pipe
  import decoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        bc_o,
  output logic              ct_o,
  output logic [2:0]        type_o,
  output logic [OPC_W-1:0]  opcode_o,
  output logic [REG_W-1:0]  rd_addr,
  output logic [REG_W-1:0]  rs1_addr,
  output logic [REG_W-1:0]  rs2_addr,
  output logic [XLEN-1:0]   imm_o,
  output logic [SYS_W-1:0]  sys_o,
  output logic              illegal_o
`ifdef DECODER_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_dec_cnt,
  output logic [31:0]       perf_ill_cnt
`endif
);

  dec_bundle_t dec_bundle;
  dec_bundle_t main_q, main_d;
  dec_bundle_t skid_q, skid_d;
  logic        main_vld_q, main_vld_d;
  logic        skid_vld_q, skid_vld_d;
  logic        in_fire;
  logic        out_fire;

  decoder_field_ext u_field_ext (
    .instr_i  (instruction),
    .bundle_o (dec_bundle)
  );

  assign in_ready = ~skid_vld_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_vld_q & out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (out_fire || !main_vld_q) begin
      // Main frees up this cycle: refill from skid first to keep FIFO order.
      // With skid full in_ready is low, so no input can collide here.
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        main_vld_d = in_fire;
        if (in_fire) begin
          main_d = dec_bundle;
        end
      end
    end else if (in_fire) begin
      skid_d     = dec_bundle;
      skid_vld_d = 1'b1;
    end
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_valid = main_vld_q;
  assign bc_o      = main_q.bc;
  assign ct_o      = main_q.ct;
  assign type_o    = main_q.cls;
  assign opcode_o  = main_q.opcode;
  assign rd_addr   = main_q.rd;
  assign rs1_addr  = main_q.rs1;
  assign rs2_addr  = main_q.rs2;
  assign imm_o     = main_q.imm;
  assign sys_o     = main_q.sys;
  assign illegal_o = main_q.illegal;

`ifdef DECODER_PIPE_PERF_CNT_EN
  logic [31:0] perf_dec_q;
  logic [31:0] perf_ill_q;

  // Counters survive flush; only reset clears them. Both wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_dec_q <= '0;
      perf_ill_q <= '0;
    end else if (out_fire) begin
      perf_dec_q <= perf_dec_q + 32'd1;
      if (main_q.illegal) begin
        perf_ill_q <= perf_ill_q + 32'd1;
      end
    end
  end

  assign perf_dec_cnt = perf_dec_q;
  assign perf_ill_cnt = perf_ill_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/decoder_pipe.md
Name: decoder_pipe

Overview:
- Registered, flow-controlled successor to the single-cycle instruction decoder.
- Sits between fetch and register-read.
- Splits the 32-bit instruction into bc/ct/opcode/rd/rs1/rs2 and classifies it by the {BC,CT} class field.
- Produces a sign-extended immediate and flags illegal classes; valid/ready handshakes on both sides, with a 2-entry skid buffer so that in_ready is a registered signal.

Parameters:
- INST_W, 32, instruction width
- XLEN, 32, width of the sign-extended immediate output
- OPC_W, 5, opcode field width
- REG_W, 5, register address width
- IMM_W, 14, short immediate width (instr[13:0])
- JIMM_W, 19, jump immediate width (instr[18:0])
- SYS_W, 24, system-op immediate width (instr[23:0])

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  drop all held entries
- in_valid  in  1  instruction present
- in_ready  out  1  decoder can accept
- instruction  in  INST_W  raw instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  consumer accepts
- bc_o  out  2  instr[31:30]
- ct_o  out  1  instr[29]
- type_o  out  3  class = {bc,ct}
- opcode_o  out  OPC_W  instr[28:24]
- rd_addr  out  REG_W  destination register
- rs1_addr  out  REG_W  source register 1
- rs2_addr  out  REG_W  source register 2
- imm_o  out  XLEN  sign-extended immediate
- sys_o  out  SYS_W  system-op immediate
- illegal_o  out  1  class 3'b111

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: all outputs are 0 except in_ready = 1. Main and skid entries are invalid.
- Decode function (combinational on the input, captured into the entry). Fields not listed for a class are 0:
  - 000 R: rd=[23:19], rs1=[18:14], rs2=[13:9], imm_o=0.
  - 001 ALU-I and 010 LOAD: rd=[23:19], rs1=[18:14], imm_o=sext([13:0]).
  - 011 STORE and 100 BRANCH: rs2=[23:19], rs1=[18:14], imm_o=sext([13:0]).
  - 101 JUMP: rd=[23:19], imm_o=sext([18:0]).
  - 110 SYSTEM: sys_o=[23:0], imm_o=0.
  - 111: illegal_o=1; bc/ct/type/opcode are still reported, all register fields and immediates are 0.
  - bc_o, ct_o, type_o and opcode_o are always driven from the instruction.
- Storage: a main entry drives the outputs directly; a skid entry holds one overflow bundle.
- Handshakes:
  - Input fires when in_valid & in_ready.
  - Output fires when out_valid & out_ready.
  - in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
- Latency: one cycle from input fire to out_valid, when main is empty or firing.
- Transitions per cycle (no flush):
  - Main empty, or main firing with skid empty: input loads main.
  - Main full and not firing, input fires: input goes to skid (in_ready drops next cycle).
  - Main firing with skid full: skid moves to main and skid empties. in_ready is 0 in this cycle, so no simultaneous input is possible.
  - Main full, not firing, skid full: everything holds. Output fields must stay stable while out_valid & !out_ready.
- flush: has priority over everything. Next cycle main and skid are invalid, out_valid=0, in_ready=1. Any input firing in the flush cycle is discarded.
- Reset mid-transfer discards all entries, the same as flush.
- Order: strict FIFO; no bundle is dropped or duplicated except by flush.

Optional Feature:
- Macro: DECODER_PIPE_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_dec_cnt[31:0] and perf_ill_cnt[31:0].
  - perf_dec_cnt increments on each output fire.
  - perf_ill_cnt increments on each output fire with illegal_o=1.
  - Both wrap at 2^32, clear on reset, and are not cleared by flush.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package decoder_pkg holds:
  - the field bit-position constants (BC 31:30, CT 29, OPCODE 28:24, RD 23:19, RS1 18:14, RS2 13:9);
  - the class enum (CLS_R, CLS_I, CLS_LD, CLS_ST, CLS_BR, CLS_J, CLS_SYS, CLS_ILL);
  - the decoded-bundle struct.
- Sub-module decoder_field_ext is purely combinational: instruction in, bundle out. decoder_pipe instantiates it and adds the skid and handshake logic.

Test Plan:
- R-type: 0x03088600 → after 1 cycle: type_o=0, opcode_o=3, rd=1, rs1=2, rs2=3, imm_o=0, illegal_o=0.
- ALU-I: 0x21283FFF → type_o=1, opcode_o=1, rd=5, rs1=0, imm_o=0xFFFFFFFF.
- JUMP: 0xA0140000 → type_o=5, rd=2, imm_o=0xFFFC0000, rs1=rs2=0.
- Illegal: 0xE0000000 → illegal_o=1, type_o=7, imm_o=0, sys_o=0; with the macro enabled, perf_ill_cnt goes 0→1 on fire.
- Backpressure: hold out_ready=0 and offer A, B, C back-to-back.
  - A and B are accepted; in_ready=0 from the cycle after B; C stalls.
  - Outputs stay stable on A.
  - Release out_ready: output sequence is A, B, C with no gaps beyond the skid refill.
- Flush: main and skid full, pulse flush together with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed-cycle input never appears at the output.
